// File: rtl/gpio_sram_shifter_if.sv
// Bundles the serial command/readback signals between a host-side driver and the shifter.
interface gpio_sram_shifter_if #(
    parameter int PKT_W  = 86,
    parameter int DATA_W = 64
);
    logic              frame_start;
    logic              ser_in;
    logic              ser_valid;
    logic [DATA_W-1:0] sram_data;
    logic [PKT_W-1:0]  packet;
    logic              packet_valid;
    logic              ser_out;
    logic              ser_out_valid;
    logic              busy;
    logic              frame_err;

    modport master (
        output frame_start, ser_in, ser_valid, sram_data,
        input  packet, packet_valid, ser_out, ser_out_valid, busy, frame_err
    );

    modport slave (
        input  frame_start, ser_in, ser_valid, sram_data,
        output packet, packet_valid, ser_out, ser_out_valid, busy, frame_err
    );
endinterface

// File: rtl/gpio_sram_shifter.sv
// Serial-in command packet assembler with delayed SRAM readback capture and serial-out.
// Frame: shift in PKT_W bits, issue packet, wait, capture readback, shift out DATA_W bits.
module gpio_sram_shifter #(
    parameter int PKT_W       = 86,
    parameter int DATA_W      = 64,
    parameter int WAIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    gpio_sram_shifter_if.slave bus
);
    localparam int MAX_LEN = (PKT_W > DATA_W) ? PKT_W : DATA_W;
    localparam int CNT_W   = ($clog2(MAX_LEN + 1) > 8) ? $clog2(MAX_LEN + 1) : 8;

    localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(PKT_W - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_OUT  = CNT_W'(DATA_W - 1);

    // Idle packet: SRAM control bits (low field) held inactive-high, opcode field zero.
    localparam logic [PKT_W-1:0] RST_PACKET = {3'b000, {(PKT_W-3){1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        ISSUE,
        WAIT,
        CAPTURE,
        SHIFT_OUT
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PKT_W-1:0]  r_shift;
    logic [DATA_W-1:0] r_out;
    logic [PKT_W-1:0]  r_packet;
    logic              r_packet_valid;
    logic              r_ser_out;
    logic              r_ser_out_valid;
    logic              r_busy;
    logic              r_frame_err;

    logic [PKT_W-1:0]  w_shift_next;

    assign w_shift_next = {r_shift[PKT_W-2:0], bus.ser_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_shift         <= '0;
            r_out           <= '0;
            r_packet        <= RST_PACKET;
            r_packet_valid  <= 1'b0;
            r_ser_out       <= 1'b0;
            r_ser_out_valid <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_err     <= 1'b0;
        end else begin
            r_packet_valid <= 1'b0;
            r_frame_err    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.frame_start) begin
                        r_state <= SHIFT_IN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                SHIFT_IN: begin
                    // A restart wins over a coincident data bit, which is dropped.
                    if (bus.frame_start) begin
                        r_cnt       <= '0;
                        r_frame_err <= 1'b1;
                    end else if (bus.ser_valid) begin
                        r_shift <= w_shift_next;
                        if (r_cnt == LAST_IN) begin
                            r_state        <= ISSUE;
                            r_cnt          <= '0;
                            r_packet       <= w_shift_next;
                            r_packet_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    r_frame_err <= bus.frame_start;
                    r_state     <= WAIT;
                    r_cnt       <= '0;
                end

                WAIT: begin
                    r_frame_err <= bus.frame_start;
                    if (r_cnt == LAST_WAIT) begin
                        r_state <= CAPTURE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                CAPTURE: begin
                    // MSB goes straight to the output pin; the rest waits in r_out.
                    r_frame_err     <= bus.frame_start;
                    r_state         <= SHIFT_OUT;
                    r_cnt           <= '0;
                    r_out           <= {bus.sram_data[DATA_W-2:0], 1'b0};
                    r_ser_out       <= bus.sram_data[DATA_W-1];
                    r_ser_out_valid <= 1'b1;
                end

                SHIFT_OUT: begin
                    r_frame_err <= bus.frame_start;
                    if (r_cnt == LAST_OUT) begin
                        r_state         <= IDLE;
                        r_cnt           <= '0;
                        r_ser_out       <= 1'b0;
                        r_ser_out_valid <= 1'b0;
                        r_busy          <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_ser_out <= r_out[DATA_W-1];
                        r_out     <= {r_out[DATA_W-2:0], 1'b0};
                    end
                end

                default: begin
                    r_state         <= IDLE;
                    r_cnt           <= '0;
                    r_ser_out       <= 1'b0;
                    r_ser_out_valid <= 1'b0;
                    r_busy          <= 1'b0;
                end
            endcase
        end
    end

    assign bus.packet        = r_packet;
    assign bus.packet_valid  = r_packet_valid;
    assign bus.ser_out       = r_ser_out;
    assign bus.ser_out_valid = r_ser_out_valid;
    assign bus.busy          = r_busy;
    assign bus.frame_err     = r_frame_err;

endmodule

// File: tb/tb_gpio_sram_shifter.sv
// Scoreboard bench for gpio_sram_shifter: packets and readback words are queued at drive time
// and compared as the DUT emits packet_valid strobes and serial readback words.
module tb_gpio_sram_shifter;
    localparam int PKT_W       = 86;
    localparam int DATA_W      = 64;
    localparam int WAIT_CYCLES = 4;
    localparam int TXN_CYCLES  = 1 + WAIT_CYCLES + 1 + DATA_W;
    localparam logic [PKT_W-1:0] RST_PKT = {3'b000, {(PKT_W-3){1'b1}}};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gpio_sram_shifter_if #(.PKT_W(PKT_W), .DATA_W(DATA_W)) bus_if ();

    gpio_sram_shifter #(
        .PKT_W      (PKT_W),
        .DATA_W     (DATA_W),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [PKT_W-1:0]  exp_pkt_q[$];
    logic [DATA_W-1:0] exp_data_q[$];

    int pv_count   = 0;
    int ferr_count = 0;
    int cyc        = 0;
    int issue_cyc  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every packet strobe and every completed readback word.
    initial begin : monitor
        logic [DATA_W-1:0] rx;
        logic [PKT_W-1:0]  ep;
        logic [DATA_W-1:0] ed;
        int                nbits;
        logic              prev_busy;
        rx        = '0;
        nbits     = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                nbits = 0;
                rx    = '0;
            end else begin
                if (bus_if.packet_valid) begin
                    pv_count++;
                    issue_cyc = cyc;
                    if (exp_pkt_q.size() == 0) begin
                        chk("pkt_unexpected", 128'(1), 128'(0));
                    end else begin
                        ep = exp_pkt_q.pop_front();
                        chk("packet", 128'(bus_if.packet), 128'(ep));
                        $display("txn packet  %h", bus_if.packet);
                    end
                end
                if (bus_if.ser_out_valid) begin
                    rx = {rx[DATA_W-2:0], bus_if.ser_out};
                    nbits++;
                    if (nbits == DATA_W) begin
                        nbits = 0;
                        if (exp_data_q.size() == 0) begin
                            chk("data_unexpected", 128'(1), 128'(0));
                        end else begin
                            ed = exp_data_q.pop_front();
                            chk("ser_data", 128'(rx), 128'(ed));
                            $display("txn readback %h", rx);
                        end
                    end
                end else begin
                    chk("ser_out_idle", 128'(bus_if.ser_out), 128'(0));
                    if (nbits != 0) begin
                        chk("ser_gap", 128'(nbits), 128'(0));
                        nbits = 0;
                    end
                end
                if (bus_if.frame_err) ferr_count++;
                if (prev_busy && !bus_if.busy)
                    chk("busy_fall", 128'(cyc - issue_cyc), 128'(TXN_CYCLES));
            end
            prev_busy = bus_if.busy;
        end
    end

    task automatic start_pulse(input logic with_valid);
        bus_if.frame_start = 1'b1;
        bus_if.ser_valid   = with_valid;
        bus_if.ser_in      = with_valid;
        @(negedge clk);
        bus_if.frame_start = 1'b0;
        bus_if.ser_valid   = 1'b0;
    endtask

    task automatic shift_bits(input logic [PKT_W-1:0] p, input int nb, input int gap);
        for (int i = PKT_W - 1; i >= PKT_W - nb; i--) begin
            repeat (gap) @(negedge clk);
            bus_if.ser_valid = 1'b1;
            bus_if.ser_in    = p[i];
            @(negedge clk);
            bus_if.ser_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 500; k++) begin
            if (!bus_if.busy) break;
            @(negedge clk);
        end
        if (k == 500) chk("idle_timeout", 128'(1), 128'(0));
    endtask

    task automatic wait_pv();
        int k;
        for (k = 0; k < 500; k++) begin
            if (bus_if.packet_valid) break;
            @(negedge clk);
        end
        if (k == 500) chk("pv_timeout", 128'(1), 128'(0));
    endtask

    task automatic wait_sov();
        int k;
        for (k = 0; k < 500; k++) begin
            if (bus_if.ser_out_valid) break;
            @(negedge clk);
        end
        if (k == 500) chk("sov_timeout", 128'(1), 128'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [PKT_W-1:0] pkt_a, pkt_b, pkt_c, pkt_d, junk;
        int               e0;

        pkt_a = {3'd2, 83'h1234};
        pkt_b = {3'd5, 83'h7ABCD_0000_1111_2222};
        pkt_c = {3'd6, 83'h5_5555_AAAA_0F0F_F0F0_1357};
        pkt_d = {3'd1, 83'h2_0000_0000_0000_0000_BEEF};
        junk  = {3'd7, 83'h7_FFFF_0000_FFFF_0000_FFFF};

        bus_if.frame_start = 1'b0;
        bus_if.ser_in      = 1'b0;
        bus_if.ser_valid   = 1'b0;
        bus_if.sram_data   = '0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_packet",        128'(bus_if.packet),        128'(RST_PKT));
        chk("rst_packet_valid",  128'(bus_if.packet_valid),  128'(0));
        chk("rst_busy",          128'(bus_if.busy),          128'(0));
        chk("rst_ser_out",       128'(bus_if.ser_out),       128'(0));
        chk("rst_ser_out_valid", 128'(bus_if.ser_out_valid), 128'(0));
        chk("rst_frame_err",     128'(bus_if.frame_err),     128'(0));
        reset = 1'b0;
        @(negedge clk);

        // ser_valid in IDLE must not start anything
        bus_if.ser_valid = 1'b1;
        bus_if.ser_in    = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.ser_valid = 1'b0;
        chk("idle_ignore_busy", 128'(bus_if.busy), 128'(0));

        // Contiguous frame
        bus_if.sram_data = 64'hDEADBEEF_CAFEF00D;
        exp_pkt_q.push_back(pkt_a);
        exp_data_q.push_back(64'hDEADBEEF_CAFEF00D);
        start_pulse(1'b0);
        shift_bits(pkt_a, PKT_W, 0);
        wait_idle();
        chk("pkt_hold", 128'(bus_if.packet), 128'(pkt_a));
        chk("pv_after_a", 128'(pv_count), 128'(1));

        // Same packet with 1-of-3 ser_valid duty cycle
        bus_if.sram_data = 64'h0123_4567_89AB_CDEF;
        exp_pkt_q.push_back(pkt_a);
        exp_data_q.push_back(64'h0123_4567_89AB_CDEF);
        start_pulse(1'b0);
        shift_bits(pkt_a, PKT_W, 2);
        wait_idle();

        // Restart after 40 bits, with a coincident data bit that must be dropped
        bus_if.sram_data = 64'hA5A5_5A5A_0000_FFFF;
        exp_pkt_q.push_back(pkt_b);
        exp_data_q.push_back(64'hA5A5_5A5A_0000_FFFF);
        e0 = ferr_count;
        start_pulse(1'b0);
        shift_bits(junk, 40, 0);
        start_pulse(1'b1);
        shift_bits(pkt_b, PKT_W, 0);
        wait_idle();
        chk("restart_ferr", 128'(ferr_count - e0), 128'(1));

        // frame_start during WAIT: error pulse only, transaction unaffected
        bus_if.sram_data = 64'h8000_0000_0000_0001;
        exp_pkt_q.push_back(pkt_c);
        exp_data_q.push_back(64'h8000_0000_0000_0001);
        e0 = ferr_count;
        start_pulse(1'b0);
        shift_bits(pkt_c, PKT_W, 0);
        wait_pv();
        repeat (2) @(negedge clk);
        bus_if.frame_start = 1'b1;
        @(negedge clk);
        bus_if.frame_start = 1'b0;
        wait_idle();
        chk("wait_ferr", 128'(ferr_count - e0), 128'(1));
        repeat (3) @(negedge clk);
        chk("no_new_frame", 128'(bus_if.busy), 128'(0));

        // Reset during readback bit 20 aborts the frame
        bus_if.sram_data = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_pkt_q.push_back(pkt_d);
        start_pulse(1'b0);
        shift_bits(pkt_d, PKT_W, 0);
        wait_sov();
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy",         128'(bus_if.busy),          128'(0));
        chk("abort_ser_out_valid",128'(bus_if.ser_out_valid), 128'(0));
        chk("abort_packet",       128'(bus_if.packet),        128'(RST_PKT));
        chk("abort_packet_valid", 128'(bus_if.packet_valid),  128'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_abort_sov", 128'(bus_if.ser_out_valid), 128'(0));
        end

        chk("pkt_q_empty",  128'(exp_pkt_q.size()),  128'(0));
        chk("data_q_empty", 128'(exp_data_q.size()), 128'(0));
        chk("pv_total",     128'(pv_count),          128'(5));
        chk("ferr_total",   128'(ferr_count),        128'(2));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gpio_sram_shifter.md
GPIO_SRAM_SHIFTER -- requirements
Module: gpio_sram_shifter

Interface
REQ-001 The block SHALL have parameter PKT_W, default 86, giving the command packet width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 64, giving the readback data width in bits.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 4, giving the cycles between packet issue and readback capture; legal range is 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port frame_start, input, 1 bit: single-cycle pulse that opens a command frame.
REQ-007 The block SHALL have port ser_in, input, 1 bit: serial command bit, MSB first.
REQ-008 The block SHALL have port ser_valid, input, 1 bit: ser_in is valid this cycle.
REQ-009 The block SHALL have port sram_data, input, DATA_W bits: registered readback word from the downstream SRAM test stage.
REQ-010 The block SHALL have port packet, output, PKT_W bits: assembled command packet.
REQ-011 The block SHALL have port packet_valid, output, 1 bit: one-cycle strobe marking a newly loaded packet.
REQ-012 The block SHALL have port ser_out, output, 1 bit: serial readback bit, MSB first.
REQ-013 The block SHALL have port ser_out_valid, output, 1 bit: ser_out is valid this cycle.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a protocol violation.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT_IN, ISSUE, WAIT, CAPTURE and SHIFT_OUT.
REQ-017 In IDLE, frame_start=1 SHALL move the FSM to SHIFT_IN and clear the bit counter; ser_valid in IDLE SHALL be ignored.
REQ-018 In SHIFT_IN, each cycle with ser_valid=1 SHALL shift ser_in into the LSB of the input shift register and increment the bit counter.
REQ-019 On the cycle the counter reaches PKT_W, the FSM SHALL move to ISSUE; ser_valid cycles are not required to be contiguous.
REQ-020 In ISSUE, packet SHALL load from the shift register and packet_valid SHALL be 1 for that single cycle; packet SHALL hold its value until the next ISSUE.
REQ-021 WAIT SHALL last exactly WAIT_CYCLES cycles and then move to CAPTURE.
REQ-022 In CAPTURE, sram_data SHALL load into the output shift register for one cycle, then the FSM SHALL move to SHIFT_OUT.
REQ-023 SHIFT_OUT SHALL last exactly DATA_W cycles, driving ser_out = output-register MSB with ser_out_valid=1 and shifting left each cycle, then return to IDLE.
REQ-024 Outside SHIFT_OUT, ser_out and ser_out_valid SHALL be 0.
REQ-025 If frame_start=1 in SHIFT_IN, the counter SHALL clear, the FSM SHALL stay in SHIFT_IN (frame restart), and frame_err SHALL pulse.
REQ-026 If frame_start and ser_valid are both 1 in that cycle, the bit SHALL be discarded and the counter SHALL be 0 afterwards.
REQ-027 If frame_start=1 in ISSUE, WAIT, CAPTURE or SHIFT_OUT, it SHALL be ignored apart from a one-cycle frame_err pulse.
REQ-028 ser_valid outside SHIFT_IN SHALL be ignored without raising frame_err.
REQ-029 The bit counter SHALL be at least 8 bits wide and SHALL never wrap within a frame.

Reset
REQ-030 While reset=1: FSM = IDLE, counters = 0, shift registers = 0.
REQ-031 While reset=1: packet[PKT_W-4:0] = all ones (SRAM controls inactive) and packet[PKT_W-1:PKT_W-3] = 0.
REQ-032 While reset=1: packet_valid, ser_out, ser_out_valid, busy and frame_err = 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no packet_valid and no further ser_out_valid.

Verification
REQ-034 Shift in 86 bits encoding packet = {3'd2, 83'h1234} -> packet_valid pulses once, packet = {3'd2, 83'h1234}, busy falls exactly 1+4+1+64 cycles after ISSUE.
REQ-035 Hold sram_data = 64'hDEADBEEF_CAFEF00D at CAPTURE -> 64 serial bits with ser_out_valid=1 reassemble to 64'hDEADBEEF_CAFEF00D.
REQ-036 Assert frame_start after 40 bits, then shift 86 new bits -> frame_err pulses once, and packet equals the second frame only.
REQ-037 Drive ser_valid as a 1-of-3 duty cycle during SHIFT_IN -> packet is identical to the contiguous case.
REQ-038 Assert reset during SHIFT_OUT bit 20 -> next cycle busy=0, ser_out_valid=0, packet = reset value.
REQ-039 Pulse frame_start during WAIT -> frame_err pulses once, and the current transaction completes unchanged.
